// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB transfer/burst encodings and arbiter state type
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    // 0 marks the undefined-length INCR burst, which never holds the grant.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               burst_beats = 5'd1;
            HBURST_INCR:                 burst_beats = 5'd0;
            HBURST_WRAP4, HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  burst_beats = 5'd8;
            default:                     burst_beats = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - request/grant signals between AHB masters and the arbiter
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 16,
    parameter int MASTER_W    = 4
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic                   HREADY;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [MASTER_W-1:0]    HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - first set request strictly after ptr, wrapping modulo N
module rr_priority_picker #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [W-1:0] cand;

    // ptr itself is visited last, so a sole requester keeps winning.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB arbiter with fixed-burst and locked-sequence hold
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 16,
    parameter int MASTER_W       = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input logic          HCLK,
    input logic          HRESET,
    ahb_arbiter_if.slave bus
);

    localparam logic [MASTER_W-1:0]    DEF_IDX   = MASTER_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state;
    logic [3:0]             cnt;
    logic                   lock_rel;
    logic [MASTER_W-1:0]    ptr;
    logic [NUM_MASTERS-1:0] grant;
    logic [MASTER_W-1:0]    grant_idx;
    logic [MASTER_W-1:0]    hmaster;
    logic                   hmastlock;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [MASTER_W-1:0]    pick_idx;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] arb_grant;
    logic [MASTER_W-1:0]    arb_idx;
    logic [4:0]             beats;
    logic                   cur_lock;

    rr_priority_picker #(
        .N (NUM_MASTERS),
        .W (MASTER_W)
    ) u_picker (
        .req   (bus.HBUSREQ),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign arb_grant = pick_valid ? pick_grant : DEF_GRANT;
    assign arb_idx   = pick_valid ? pick_idx   : DEF_IDX;
    assign beats     = burst_beats(bus.HBURST);
    assign cur_lock  = bus.HLOCK[grant_idx];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ARB;
            cnt       <= 4'd0;
            lock_rel  <= 1'b0;
            ptr       <= DEF_IDX;
            grant     <= DEF_GRANT;
            grant_idx <= DEF_IDX;
            hmaster   <= DEF_IDX;
            hmastlock <= 1'b0;
        end else if (bus.HREADY) begin
            hmaster   <= grant_idx;
            hmastlock <= cur_lock;
            // A locked owner outranks any burst bookkeeping.
            if (cur_lock) begin
                state    <= LOCKED;
                lock_rel <= 1'b0;
            end else begin
                case (state)
                    LOCKED: begin
                        // One extra transfer is owed after HLOCK drops.
                        if (!lock_rel) begin
                            lock_rel <= 1'b1;
                        end else begin
                            state     <= ARB;
                            lock_rel  <= 1'b0;
                            grant     <= arb_grant;
                            grant_idx <= arb_idx;
                            ptr       <= arb_idx;
                        end
                    end
                    BURST: begin
                        if (bus.HTRANS == HTRANS_SEQ) begin
                            cnt <= cnt - 4'd1;
                            // Hand over as the count reaches 1 so the grant is ready for the last beat.
                            if (cnt <= 4'd2) begin
                                state     <= ARB;
                                grant     <= arb_grant;
                                grant_idx <= arb_idx;
                                ptr       <= arb_idx;
                            end
                        end else if (bus.HTRANS != HTRANS_BUSY) begin
                            state     <= ARB;
                            cnt       <= 4'd0;
                            grant     <= arb_grant;
                            grant_idx <= arb_idx;
                            ptr       <= arb_idx;
                        end
                    end
                    default: begin
                        if (bus.HTRANS == HTRANS_NONSEQ && beats > 5'd1) begin
                            state <= BURST;
                            cnt   <= 4'(beats - 5'd1);
                        end else begin
                            grant     <= arb_grant;
                            grant_idx <= arb_idx;
                            ptr       <= arb_idx;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.HGRANT    = grant;
    assign bus.HMASTER   = hmaster;
    assign bus.HMASTLOCK = hmastlock;

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Central AHB bus arbiter for up to 16 masters. It sits directly upstream of master_multiplexer.
- Drives the one-hot grant vector to masters and the registered HMASTER index that steers the master multiplexer's address/control/data selection.
- Round-robin fairness, default master when the bus is idle, and no re-arbitration inside fixed-length bursts or locked sequences.

Parameters:
- NUM_MASTERS, 16, number of requesting masters (2..16).
- MASTER_W, 4, width of the HMASTER index (clog2 of NUM_MASTERS, minimum 1).
- DEFAULT_MASTER, 0, index granted when no master requests.

Ports:
- HCLK  input  1  bus clock, all state updates on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HBUSREQ  input  NUM_MASTERS  per-master bus request.
- HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  input  2  transfer type on the muxed bus (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
- HBURST  input  3  burst type on the muxed bus (SINGLE=000, INCR=001, WRAP4/INCR4=010/011, WRAP8/INCR8=100/101, WRAP16/INCR16=110/111).
- HREADY  input  1  bus ready; transfer completes when high.
- HGRANT  output  NUM_MASTERS  one-hot grant, registered.
- HMASTER  output  MASTER_W  index of the master owning the address phase, registered.
- HMASTLOCK  output  1  current address-phase transfer is locked, registered.

Behaviour:
- Reset, with HRESET high at an edge:
  - HGRANT = 1<<DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0.
  - State ARB, beat counter = 0, round-robin pointer = DEFAULT_MASTER.
  - Reset mid-burst or mid-lock aborts immediately to these values.
- Handover: HGRANT may change only on an edge where HREADY=1.
  - HMASTER and HMASTLOCK load on every edge with HREADY=1: HMASTER takes the index of the set HGRANT bit, HMASTLOCK takes HLOCK of that master.
  - This gives exactly one cycle of grant-to-ownership latency.
  - HREADY=0 freezes all outputs, the state and the counter.
- State ARB:
  - Each edge with HREADY=1, the next grant is the first requesting master found searching from pointer+1 upward, with wrap-around modulo NUM_MASTERS.
  - If HBUSREQ is all zero, grant DEFAULT_MASTER.
  - The pointer updates to the newly granted index.
  - A sole requester is re-granted indefinitely.
- Transition to BURST: when HREADY=1 and HTRANS=NONSEQ with HBURST fixed-length.
  - Load the beat counter with beats-1 (3, 7 or 15).
  - Hold the grant.
- State BURST:
  - Each edge with HREADY=1 and HTRANS=SEQ decrements the counter.
  - BUSY does not decrement.
  - When the counter reaches 1, re-arbitrate at that edge so the new grant is valid during the final beat; the state returns to ARB.
  - HTRANS=IDLE or NONSEQ during BURST (early termination) returns to ARB and re-arbitrates on that edge.
- SINGLE and INCR bursts never hold the grant; arbitration runs every HREADY cycle.
- Transition to LOCKED: entered when the granted master has HLOCK=1 and HREADY=1.
  - The grant is held regardless of other requests, and the BURST counter is ignored.
- State LOCKED:
  - Exit to ARB on the first edge with HREADY=1 after the granted master's HLOCK has gone low and one further transfer has completed. This holds the grant for the extra transfer AHB requires.
- Simultaneous events:
  - LOCK takes priority over BURST, which takes priority over ARB.
  - If the granted master drops HBUSREQ mid-burst, the grant is still held until burst end.
- Indexes ≥ NUM_MASTERS are never produced.
- SPLIT/RETRY are not supported; HRESP is not an input.

Decomposition:
- Package ahb_pkg:
  - HTRANS and HBURST encoding constants.
  - A burst_beats function mapping HBURST to 1/4/8/16 (0 = undefined-length INCR).
  - Arbiter state encoding ARB/BURST/LOCKED.
- One combinational sub-module, rr_priority_picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, index and a valid flag.
  - Reused by a future slave-side decoder.

Test Plan:
- Reset: assert HRESET 2 cycles with HBUSREQ=16'hFFFF -> HGRANT=16'h0001, HMASTER=0, HMASTLOCK=0 throughout; first HREADY edge after release grants master 1.
- Round-robin: HBUSREQ=16'h0025 (masters 0, 2, 5), HREADY=1, HTRANS=NONSEQ with HBURST=SINGLE every cycle -> grants cycle 0 → 2 → 5 → 0; HMASTER follows one cycle later.
- Fixed burst hold: master 3 grants and issues INCR8 with NONSEQ then 7 SEQ beats, one BUSY inserted, master 7 also requesting -> HGRANT stays 16'h0008 until the 7th beat edge, then becomes 16'h0080.
- Early termination: WRAP16 from master 2 with HTRANS=IDLE after 3 beats and master 4 requesting -> grant moves to master 4 on that edge.
- Wait states: HREADY=0 for 4 cycles during handover -> HGRANT, HMASTER and the counter are unchanged until HREADY=1.
- Lock: master 6 asserts HLOCK for 3 transfers while master 1 requests -> HMASTLOCK=1 for those transfers, grant is held one transfer after HLOCK falls, then master 1 is granted.
